// File: rtl/tm1638_frame_ctrl.sv
// tm1638_frame_ctrl: pushes one frame of six 7-segment digits to a TM1638
// board over its write-only STB/CLK/DIO bus. One start pulse sends the mode
// command, the address command plus 16 data bytes, and the display-on command.
module tm1638_frame_ctrl #(
    parameter int         CLK_DIV = 25,    // clki cycles per half-period of tm_clk
    parameter logic [2:0] BRIGHT  = 3'd7   // brightness field of the display-on command
) (
    input  logic       clki,
    input  logic       rs,
    input  logic       start,
    input  logic [3:0] led1,
    input  logic [3:0] led2,
    input  logic [3:0] led3,
    input  logic [3:0] led4,
    input  logic [3:0] led5,
    input  logic [3:0] led6,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE, GRP_A, GAP_A, GRP_B, GAP_B, GRP_C, GAP_C, FIN
    } state_t;

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] div_q,   div_d;    // cycles within the current half-period
    logic          half_q,  half_d;   // 0: tm_clk low phase, 1: tm_clk high phase
    logic [2:0]    bit_q,   bit_d;    // bit within the current byte, LSB first
    logic [4:0]    byte_q,  byte_d;   // byte within the current group
    logic [23:0]   dig_q,   dig_d;    // latched digits, led1 in [3:0]

    logic   tick, slot_end, byte_end, in_grp;
    logic [3:0] addr, nib;
    logic [7:0] tx_byte;

    // BCD to {dp,g,f,e,d,c,b,a}; codes 10..15 are blanked
    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    assign in_grp   = (state_q == GRP_A) || (state_q == GRP_B) || (state_q == GRP_C);
    assign tick     = (div_q == DIV_LAST);
    assign slot_end = tick && half_q;
    assign byte_end = slot_end && (bit_q == 3'd7);

    // State register: FSM state, bit-timing counters and the digit latch
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            // NOTE: every flop is cleared here, including the digit latch, so an
            // abandoned frame leaves no stale state behind; sequential blocks use <=.
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            byte_q  <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            dig_q   <= dig_d;
        end
    end

    // Next state: walk the bit slots of each group and gap, then return to IDLE
    always_comb begin
        // NOTE: hold-value defaults first so no path through this block infers a latch.
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        dig_d   = dig_q;

        // Half-period divider runs in groups and gaps alike (a gap is one slot long)
        if (state_q != IDLE && state_q != FIN) begin
            if (tick) begin
                div_d  = '0;
                half_d = ~half_q;
            end else begin
                div_d  = div_q + DW'(1);
            end
        end
        if (in_grp && slot_end) bit_d  = bit_q + 3'd1;
        if (in_grp && byte_end) byte_d = byte_q + 5'd1;

        case (state_q)
            IDLE:  if (start) begin
                       state_d = GRP_A;
                       dig_d   = {led6, led5, led4, led3, led2, led1};
                   end
            GRP_A: if (byte_end) begin
                       state_d = GAP_A;
                       byte_d  = '0;
                   end
            GAP_A: if (slot_end) state_d = GRP_B;
            GRP_B: if (byte_end && byte_q == 5'd16) begin
                       state_d = GAP_B;
                       byte_d  = '0;
                   end
            GAP_B: if (slot_end) state_d = GRP_C;
            GRP_C: if (byte_end) begin
                       state_d = GAP_C;
                       byte_d  = '0;
                   end
            GAP_C: if (slot_end) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: select the byte on the wire and drive the bus from state and counters
    always_comb begin
        addr = byte_q[3:0] - 4'd1;     // display address of a GRP_B data byte
        case (addr[3:1])
            3'd0:    nib = dig_q[3:0];
            3'd1:    nib = dig_q[7:4];
            3'd2:    nib = dig_q[11:8];
            3'd3:    nib = dig_q[15:12];
            3'd4:    nib = dig_q[19:16];
            3'd5:    nib = dig_q[23:20];
            default: nib = 4'hF;       // addresses 0x0C and 0x0E decode to blank
        endcase

        case (state_q)
            GRP_A:   tx_byte = 8'h40;
            GRP_B:   tx_byte = (byte_q == 5'd0) ? 8'hC0 : (addr[0] ? 8'h00 : seg7(nib));
            GRP_C:   tx_byte = {5'b10001, BRIGHT};
            default: tx_byte = 8'hFF;
        endcase

        tm_stb = ~in_grp;
        tm_clk = in_grp ? half_q : 1'b1;
        tm_dio = in_grp ? tx_byte[bit_q] : 1'b1;
        busy   = (state_q != IDLE);
        done   = (state_q == FIN);
    end

endmodule
